// File: rtl/decoder_rotflag_pkg.sv
// Shared constants and types for the sequential rotate/flag decoder.
// Op ids, FSM states, index selectors, prefix bytes and the decode record layout.
package decoder_rotflag_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_RLC  = 4'd1;
  localparam logic [3:0] OP_RRC  = 4'd2;
  localparam logic [3:0] OP_RL   = 4'd3;
  localparam logic [3:0] OP_RR   = 4'd4;
  localparam logic [3:0] OP_SLA  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_CPL  = 4'd9;
  localparam logic [3:0] OP_SCF  = 4'd10;
  localparam logic [3:0] OP_CCF  = 4'd11;

  localparam logic [1:0] IDX_NONE = 2'b00;
  localparam logic [1:0] IDX_IX   = 2'b01;
  localparam logic [1:0] IDX_IY   = 2'b10;

  localparam logic [7:0] PFX_CB = 8'hCB;
  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CB   = 3'd1,
    ST_IDX  = 3'd2,
    ST_XD   = 3'd3,
    ST_XOP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       hit;
    logic       acc_form;
    logic [2:0] reg_f;
    logic [1:0] indexed;
    logic [7:0] disp;
    logic       wb_copy;
    logic       illegal;
    logic [7:0] opcode;
  } rec_t;

  function automatic logic [1:0] idx_of(input logic [7:0] b);
    return (b == PFX_DD) ? IDX_IX : IDX_IY;
  endfunction

endpackage

// File: rtl/decoder_rotflag_opmap.sv
// Combinational op lookup: maps the final opcode byte to an op id.
// cb_form selects the CB 00ooorrr table instead of the unprefixed 00eee111 table.
module decoder_rotflag_opmap
  import decoder_rotflag_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic       cb_form,
  input  logic       enable_undoc,
  output logic [3:0] op,
  output logic       illegal
);

  always_comb begin
    op      = OP_NONE;
    illegal = 1'b0;
    if (opcode[7:6] == 2'b00) begin
      if (cb_form) begin
        case (opcode[5:3])
          3'd0: op = OP_RLC;
          3'd1: op = OP_RRC;
          3'd2: op = OP_RL;
          3'd3: op = OP_RR;
          3'd4: op = OP_SLA;
          3'd5: op = OP_SRA;
          3'd6: begin
            if (enable_undoc) op = OP_SLL;
            else              illegal = 1'b1;
          end
          default: op = OP_SRL;
        endcase
      end else if (opcode[2:0] == 3'b111) begin
        // eee=100 is DAA, which is outside this group
        case (opcode[5:3])
          3'd0:    op = OP_RLC;
          3'd1:    op = OP_RRC;
          3'd2:    op = OP_RL;
          3'd3:    op = OP_RR;
          3'd5:    op = OP_CPL;
          3'd6:    op = OP_SCF;
          3'd7:    op = OP_CCF;
          default: op = OP_NONE;
        endcase
      end
    end
  end

endmodule

// File: rtl/decoder_rotflag_seq.sv
// Sequential rotate/flag decoder: consumes opcode bytes, tracks CB/DD/FD prefixes
// and emits one registered decode record per instruction.
module decoder_rotflag_seq
  import decoder_rotflag_pkg::*;
#(
  parameter bit ENABLE_INDEX = 1'b1,
  parameter bit ENABLE_UNDOC = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       Flush,
  input  logic [7:0] In_Byte,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic [3:0] Out_Op,
  output logic       Out_Hit,
  output logic       Out_AccForm,
  output logic [2:0] Out_Reg,
  output logic [1:0] Out_Indexed,
  output logic [7:0] Out_Disp,
  output logic       Out_WbCopy,
  output logic       Out_Illegal,
  output logic [7:0] Out_Opcode,
  output logic [2:0] dbg_state
);

  // Handshake: a byte transfers when In_Valid & In_Ready & ~Flush at a rising edge;
  // a record transfers when Out_Valid & Out_Ready. Out_Valid holds until taken.
  // With one output register, new bytes are accepted only if that register is
  // empty or is being drained in the same cycle. Flush beats both transfers.

  state_t     state, state_nxt;
  logic [1:0] idx_q, idx_nxt;
  logic [7:0] disp_q, disp_nxt;
  logic       out_valid_q;
  rec_t       rec_q, rec_nxt;
  logic       emit;
  logic       accept;
  logic       is_index_pfx;
  logic [3:0] map_op;
  logic       map_illegal;

  assign In_Ready     = ~out_valid_q | Out_Ready;
  assign accept       = In_Valid & In_Ready & ~Flush;
  assign is_index_pfx = (In_Byte == PFX_DD) || (In_Byte == PFX_FD);

  decoder_rotflag_opmap u_opmap (
    .opcode       (In_Byte),
    .cb_form      ((state == ST_CB) || (state == ST_XOP)),
    .enable_undoc (ENABLE_UNDOC),
    .op           (map_op),
    .illegal      (map_illegal)
  );

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx_q;
    disp_nxt        = disp_q;
    emit            = 1'b0;
    rec_nxt         = '0;
    rec_nxt.op      = map_op;
    rec_nxt.hit     = (map_op != OP_NONE);
    rec_nxt.illegal = map_illegal;
    rec_nxt.opcode  = In_Byte;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (In_Byte == PFX_CB) begin
            state_nxt = ST_CB;
          end else if (ENABLE_INDEX && is_index_pfx) begin
            state_nxt = ST_IDX;
            idx_nxt   = idx_of(In_Byte);
          end else begin
            emit             = 1'b1;
            rec_nxt.acc_form = rec_nxt.hit;
            rec_nxt.reg_f    = rec_nxt.hit ? 3'd7 : 3'd0;
          end
        end
        ST_CB: begin
          emit          = 1'b1;
          rec_nxt.reg_f = In_Byte[2:0];
          state_nxt     = ST_IDLE;
        end
        ST_IDX: begin
          if (is_index_pfx) begin
            idx_nxt = idx_of(In_Byte);
          end else if (In_Byte == PFX_CB) begin
            state_nxt = ST_XD;
          end else begin
            // A prefix has no effect on accumulator forms; only Indexed records it
            emit             = 1'b1;
            rec_nxt.acc_form = rec_nxt.hit;
            rec_nxt.reg_f    = rec_nxt.hit ? 3'd7 : 3'd0;
            rec_nxt.indexed  = idx_q;
            state_nxt        = ST_IDLE;
          end
        end
        ST_XD: begin
          disp_nxt  = In_Byte;
          state_nxt = ST_XOP;
        end
        ST_XOP: begin
          emit            = 1'b1;
          rec_nxt.reg_f   = 3'd6;
          rec_nxt.indexed = idx_q;
          rec_nxt.disp    = disp_q;
          rec_nxt.wb_copy = ENABLE_UNDOC && (In_Byte[2:0] != 3'd6);
          state_nxt       = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (emit) begin
      idx_nxt  = IDX_NONE;
      disp_nxt = 8'h00;
    end
    if (Flush) begin
      state_nxt = ST_IDLE;
      idx_nxt   = IDX_NONE;
      disp_nxt  = 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      idx_q  <= IDX_NONE;
      disp_q <= 8'h00;
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      disp_q <= disp_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid_q <= 1'b0;
      rec_q       <= '0;
    end else if (Flush) begin
      out_valid_q <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      rec_q       <= rec_nxt;
    end else if (Out_Ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign Out_Valid   = out_valid_q;
  assign Out_Op      = rec_q.op;
  assign Out_Hit     = rec_q.hit;
  assign Out_AccForm = rec_q.acc_form;
  assign Out_Reg     = rec_q.reg_f;
  assign Out_Indexed = rec_q.indexed;
  assign Out_Disp    = rec_q.disp;
  assign Out_WbCopy  = rec_q.wb_copy;
  assign Out_Illegal = rec_q.illegal;
  assign Out_Opcode  = rec_q.opcode;
  assign dbg_state   = state;

endmodule
